// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the open-collector clock/data pair. The sequence is:
//   1. Pull the clock low (request-to-send).
//   2. Release the clock and drive the start bit.
//   3. Shift D0..D7, odd parity and stop on device-generated falling edges.
//   4. Check the device ACK and wait for the bus to go idle.
// Every phase is guarded by a timeout. The companion receiver is held off
// through rx_inhibit whenever a transfer is in flight.
//
// Optional build macro:
//   PS2_TX_RETRY_EN - retry a failed transfer up to MAX_RETRY times before
//                     reporting tx_error.
//
// Ports:
//   sys_clk     in   system clock
//   reset       in   asynchronous active-low reset
//   tx_data     in   [7:0] command byte, taken when tx_valid && tx_ready
//   tx_valid    in   request to send tx_data
//   tx_ready    out  high only while idle
//   tx_done     out  one-cycle pulse: byte sent and acknowledged
//   tx_error    out  one-cycle pulse: timeout or NACK
//   rx_inhibit  out  high whenever not idle
//   ps2_clk_in  in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in in   raw PS/2 data line level (asynchronous)
//   ps2_clk_oe  out  1 = pull clock line low
//   ps2_data_oe out  1 = pull data line low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int EDGE_TIMEOUT   = 30000
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRY    = 2
`endif
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] EDGE_LAST  = 20'(EDGE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_clkSync;
  logic [1:0]  r_dataSync;
  logic        r_clkPrev;
  logic [9:0]  r_frame;
  logic [3:0]  r_bitIdx;
  logic        r_ackBit;
  logic [19:0] r_cnt;
  logic        r_clkOe;
  logic        r_dataOe;
  logic        r_txDone;
  logic        r_txError;

  logic        w_clkS;
  logic        w_dataS;
  logic        w_fall;
  logic [3:0]  w_nextIdx;
  logic [3:0]  w_bitIdxNext;
  logic        w_ackBitNext;
  logic        w_clkOeNext;
  logic        w_dataOeNext;
  logic        w_doneNext;
  logic        w_errorNext;
  logic        w_load;
  logic        w_edgeClr;
  logic        w_failed;

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry;
  logic          w_retryInc;
`endif

  assign w_clkS     = r_clkSync[1];
  assign w_dataS    = r_dataSync[1];
  assign w_fall     = r_clkPrev & ~w_clkS;
  assign w_nextIdx  = r_bitIdx + 4'd1;
  assign tx_ready   = (r_state == S_IDLE);
  assign rx_inhibit = (r_state != S_IDLE);
  assign tx_done    = r_txDone;
  assign tx_error   = r_txError;
  assign ps2_clk_oe  = r_clkOe;
  assign ps2_data_oe = r_dataOe;

  // Two-stage synchronizers for the bus lines, plus the previous synchronized
  // clock for falling-edge detection. They reset to the idle-high level so a
  // release from reset never looks like an edge.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_in};
      r_dataSync <= {r_dataSync[0], ps2_data_in};
      r_clkPrev  <= w_clkS;
    end
  end

  // Next-state and next-output decode. Line enables and pulses are computed
  // here and registered below, so the bus never sees combinational glitches.
  // In START/SHIFT a falling edge is tested before the timeout so an edge
  // landing on the final timeout cycle still counts.
  always_comb begin
    w_stateNext  = r_state;
    w_clkOeNext  = r_clkOe;
    w_dataOeNext = r_dataOe;
    w_doneNext   = 1'b0;
    w_errorNext  = 1'b0;
    w_bitIdxNext = r_bitIdx;
    w_ackBitNext = r_ackBit;
    w_load       = 1'b0;
    w_edgeClr    = 1'b0;
    w_failed     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_retryInc   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_load       = 1'b1;
          w_stateNext  = S_INHIBIT;
          w_clkOeNext  = 1'b1;
          w_dataOeNext = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_stateNext  = S_START;
          w_clkOeNext  = 1'b0;
          w_dataOeNext = 1'b1;
        end
      end
      S_START: begin
        if (w_fall) begin
          w_edgeClr    = 1'b1;
          w_stateNext  = S_SHIFT;
          w_bitIdxNext = 4'd0;
          w_dataOeNext = ~r_frame[0];
        end else if (r_cnt == START_LAST) begin
          w_failed = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_edgeClr = 1'b1;
          if (r_bitIdx == 4'd9) begin
            w_ackBitNext = w_dataS;
            w_stateNext  = S_ACK;
          end else begin
            w_bitIdxNext = w_nextIdx;
            w_dataOeNext = ~r_frame[w_nextIdx];
          end
        end else if (r_cnt == EDGE_LAST) begin
          w_failed = 1'b1;
        end
      end
      S_ACK: begin
        if (r_ackBit) begin
          w_failed = 1'b1;
        end else begin
          w_stateNext = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_clkS && w_dataS) begin
          w_stateNext = S_IDLE;
          w_doneNext  = 1'b1;
        end else if (w_fall) begin
          w_edgeClr = 1'b1;
        end else if (r_cnt == EDGE_LAST) begin
          w_failed = 1'b1;
        end
      end
      default: begin
        w_stateNext  = S_IDLE;
        w_clkOeNext  = 1'b0;
        w_dataOeNext = 1'b0;
      end
    endcase

    // A failed attempt releases the data line at once; with retries enabled
    // the clock goes straight back into request-to-send with the same frame.
    if (w_failed) begin
      w_clkOeNext  = 1'b0;
      w_dataOeNext = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (r_retry < RW'(MAX_RETRY)) begin
        w_retryInc  = 1'b1;
        w_stateNext = S_INHIBIT;
        w_clkOeNext = 1'b1;
      end else begin
        w_stateNext = S_IDLE;
        w_errorNext = 1'b1;
      end
`else
      w_stateNext = S_IDLE;
      w_errorNext = 1'b1;
`endif
    end
  end

  // State, frame and registered bus outputs. The shared phase counter restarts
  // on every state change and on each device falling edge.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_frame   <= 10'd0;
      r_bitIdx  <= 4'd0;
      r_ackBit  <= 1'b0;
      r_cnt     <= 20'd0;
      r_clkOe   <= 1'b0;
      r_dataOe  <= 1'b0;
      r_txDone  <= 1'b0;
      r_txError <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_bitIdx  <= w_bitIdxNext;
      r_ackBit  <= w_ackBitNext;
      r_clkOe   <= w_clkOeNext;
      r_dataOe  <= w_dataOeNext;
      r_txDone  <= w_doneNext;
      r_txError <= w_errorNext;
      if (w_load) begin
        r_frame <= {1'b1, ~^tx_data, tx_data};
      end
      if ((r_state == S_IDLE) || (w_stateNext != r_state) || w_edgeClr) begin
        r_cnt <= 20'd0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Retry count: cleared when a new byte is accepted, stepped on each retry.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_retry <= '0;
    end else if (w_load) begin
      r_retry <= '0;
    end else if (w_retryInc) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A behavioural keyboard model clocks the
// bus, samples each bit in the clock-low phase and optionally ACKs. Timeouts
// are shortened through parameters so every scenario runs quickly.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int STO  = 400;
  localparam int ETO  = 200;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int inhCnt = 0;
  logic prevClkOe = 1'b0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT(STO),
    .EDGE_TIMEOUT(ETO)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 sys_clk = ~sys_clk;

  // Open-collector bus: a line is low if either side pulls it.
  assign ps2_clk_in  = ~(ps2_clk_oe | devClkLow);
  assign ps2_data_in = ~(ps2_data_oe | devDataLow);

  // Pulse and request-to-send counters, sampled on the falling clock edge.
  always @(negedge sys_clk) begin
    if (tx_done) doneCnt <= doneCnt + 1;
    if (tx_error) errCnt <= errCnt + 1;
    if (ps2_clk_oe && !prevClkOe) inhCnt <= inhCnt + 1;
    prevClkOe <= ps2_clk_oe;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference frame: data LSB first, odd parity bit, stop bit released (1).
  function automatic logic [9:0] expectedBits(input logic [7:0] b);
    logic [9:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[i];
    r[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    r[9] = 1'b1;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: wait for request-to-send, then generate nEdges clock
  // pulses, capturing the data line late in each low phase. With ack set it
  // pulls data low before the 11th falling edge and releases it on the rise.
  task automatic deviceFrame(input int nEdges, input bit ack,
                             output logic [9:0] bits, output bit seenStart);
    seenStart = 1'b0;
    bits = '1;
    for (int i = 0; i < INH + STO + 100; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) begin
        seenStart = 1'b1;
        break;
      end
      tick(1);
    end
    if (!seenStart) return;
    tick(10);
    for (int e = 1; e <= nEdges; e++) begin
      devClkLow = 1'b1;
      tick(HALF);
      if (e <= 10) bits[e-1] = ps2_data_in;
      devClkLow = 1'b0;
      if (e == 11) devDataLow = 1'b0;
      if (e == 10 && ack) begin
        tick(HALF / 2);
        devDataLow = 1'b1;
        tick(HALF - HALF / 2);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_done: got %b expected 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_error: got %b expected 0", tx_error); end
    checks++; if (rx_inhibit !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_inhibit: got %b expected 0", rx_inhibit); end
    reset = 1'b1;
    tick(3);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_send(input logic [7:0] b);
    int d0, e0, n;
    logic [9:0] bits;
    bit ok;
    d0 = doneCnt; e0 = errCnt;
    applyStimulus(b);
    checks++; if (rx_inhibit !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL send_busy %h: got inhibit=%b ready=%b expected 1/0", b, rx_inhibit, tx_ready); end
    n = 0;
    while (ps2_clk_oe && n < INH + 10) begin tick(1); n++; end
    checks++; if (n !== INH) begin errors++; $display("[TB] FAIL inhibit_len %h: got %0d expected %0d", b, n, INH); end
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("[TB] FAIL start_bit %h: got %b expected 1", b, ps2_data_oe); end
    deviceFrame(11, 1'b1, bits, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL send_rts %h: got none expected request-to-send", b); end
    checks++; if (bits !== expectedBits(b)) begin errors++; $display("[TB] FAIL frame_bits %h: got %b expected %b", b, bits, expectedBits(b)); end
    for (int i = 0; i < 200 && doneCnt == d0; i++) tick(1);
    tick(5);
    checks++; if (doneCnt !== d0 + 1) begin errors++; $display("[TB] FAIL done_pulses %h: got %0d expected 1", b, doneCnt - d0); end
    checks++; if (errCnt !== e0) begin errors++; $display("[TB] FAIL send_no_error %h: got %0d expected 0", b, errCnt - e0); end
    checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL send_idle %h: got ready=%b clk=%b data=%b expected 1/0/0", b, tx_ready, ps2_clk_oe, ps2_data_oe); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) test_send(8'($urandom_range(0, 255)));
  endtask

  task automatic test_start_timeout();
    int e0, i0, n;
    bit found, prevD;
    e0 = errCnt; i0 = inhCnt;
    applyStimulus(8'h5A);
    n = 0; found = 1'b0; prevD = 1'b0;
    for (int c = 0; c < ATTEMPTS * (INH + STO + 20); c++) begin
      tick(1);
      n++;
      if (ps2_data_oe && !prevD) n = 0;
      prevD = ps2_data_oe;
      if (tx_error) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL start_timeout_seen: got none expected tx_error"); end
    checks++; if (n !== STO) begin errors++; $display("[TB] FAIL start_timeout_len: got %0d expected %0d", n, STO); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL start_timeout_release: got clk=%b data=%b expected 0/0", ps2_clk_oe, ps2_data_oe); end
    tick(1);
    checks++; if (errCnt !== e0 + 1) begin errors++; $display("[TB] FAIL start_timeout_pulses: got %0d expected 1", errCnt - e0); end
    checks++; if (inhCnt - i0 !== ATTEMPTS) begin errors++; $display("[TB] FAIL start_timeout_rts: got %0d expected %0d", inhCnt - i0, ATTEMPTS); end
  endtask

  task automatic test_nack();
    int d0, e0, i0;
    logic [9:0] bits;
    bit ok;
    d0 = doneCnt; e0 = errCnt; i0 = inhCnt;
    applyStimulus(8'hED);
    for (int a = 0; a < ATTEMPTS; a++) begin
      deviceFrame(11, 1'b0, bits, ok);
      checks++; if (!ok || bits !== expectedBits(8'hED)) begin errors++; $display("[TB] FAIL nack_frame %0d: got %b expected %b", a, bits, expectedBits(8'hED)); end
    end
    tick(20);
    checks++; if (errCnt !== e0 + 1) begin errors++; $display("[TB] FAIL nack_error: got %0d expected 1", errCnt - e0); end
    checks++; if (doneCnt !== d0) begin errors++; $display("[TB] FAIL nack_no_done: got %0d expected 0", doneCnt - d0); end
    checks++; if (inhCnt - i0 !== ATTEMPTS) begin errors++; $display("[TB] FAIL nack_rts: got %0d expected %0d", inhCnt - i0, ATTEMPTS); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL nack_idle: got %b expected 1", tx_ready); end
  endtask

  task automatic test_edge_timeout();
    int d0, e0, n;
    logic [9:0] bits;
    bit ok;
    d0 = doneCnt; e0 = errCnt;
    applyStimulus(8'h3C);
    for (int a = 0; a < ATTEMPTS; a++) begin
      deviceFrame(3, 1'b0, bits, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL edge_rts %0d: got none expected request-to-send", a); end
      if (a == 0) applyStimulus(8'h00);
      devClkLow = 1'b1;
      n = 0;
      for (int c = 0; c < ETO + 50; c++) begin
        tick(1);
        n++;
        if (n == HALF) devClkLow = 1'b0;
        if (tx_error || (ps2_clk_oe && a < ATTEMPTS - 1)) break;
      end
      devClkLow = 1'b0;
      checks++; if (n !== ETO + 3) begin errors++; $display("[TB] FAIL edge_timeout_len %0d: got %0d expected %0d", a, n, ETO + 3); end
    end
    checks++; if (tx_error !== 1'b1) begin errors++; $display("[TB] FAIL edge_timeout_pulse: got %b expected 1", tx_error); end
    tick(INH + 20);
    checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL ignored_valid: got ready=%b clk=%b expected 1/0", tx_ready, ps2_clk_oe); end
    checks++; if (errCnt !== e0 + 1 || doneCnt !== d0) begin errors++; $display("[TB] FAIL edge_timeout_pulses: got err=%0d done=%0d expected 1/0", errCnt - e0, doneCnt - d0); end
  endtask

  task automatic test_reset_mid_shift();
    int d0, e0;
    logic [9:0] bits;
    bit ok;
    d0 = doneCnt; e0 = errCnt;
    applyStimulus(8'h00);
    deviceFrame(3, 1'b0, bits, ok);
    checks++; if (rx_inhibit !== 1'b1 || ps2_data_oe !== 1'b1) begin errors++; $display("[TB] FAIL mid_shift: got inhibit=%b data=%b expected 1/1", rx_inhibit, ps2_data_oe); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_lines: got clk=%b data=%b expected 0/0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1 || rx_inhibit !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready: got ready=%b inhibit=%b expected 1/0", tx_ready, rx_inhibit); end
    @(posedge sys_clk); #1;
    tick(3);
    reset = 1'b1;
    tick(10);
    checks++; if (doneCnt !== d0 || errCnt !== e0) begin errors++; $display("[TB] FAIL reset_no_pulse: got done=%0d err=%0d expected 0/0", doneCnt - d0, errCnt - e0); end
  endtask

  initial begin
    test_reset();
    test_send(8'hED);
    test_send(8'h01);
    test_random();
    test_start_timeout();
    test_nack();
    test_edge_timeout();
    test_send(8'hFF);
    test_reset_mid_shift();
    test_send(8'h5C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic, etc.) to the keyboard over the shared open-collector clock and data lines. It sits beside the keyboard receiver, and the receiver is held off (rx_inhibit) while a transfer is in progress. It generates the request-to-send sequence, shifts data on device-generated clock edges, checks the device ACK, and guards every phase with a timeout.

Parameters:
INHIBIT_CYCLES, 5000, sys_clk cycles the clock line is held low for request-to-send (100 us at 50 MHz)
START_TIMEOUT, 750000, max cycles from clock release to first device falling edge (15 ms)
EDGE_TIMEOUT, 30000, max cycles between consecutive device falling edges, and for the final line-idle wait
MAX_RETRY, 2, retry attempts when PS2_TX_RETRY_EN is defined

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tx_data  in  8  command byte, sampled when tx_valid && tx_ready
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high in IDLE only
tx_done  out  1  one-cycle pulse: byte sent and ACK received
tx_error  out  1  one-cycle pulse: timeout or missing ACK (after retries if enabled)
rx_inhibit  out  1  high in every state except IDLE
ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous)
ps2_data_in  in  1  raw PS/2 data line level (asynchronous)
ps2_clk_oe  out  1  1 = drive clock line low, 0 = release
ps2_data_oe  out  1  1 = drive data line low, 0 = release

Behaviour:
- Reset (asserted low, asynchronous): state IDLE, both line enables 0, tx_ready=1, tx_done=0, tx_error=0, rx_inhibit=0, all counters 0.
- ps2_clk_in and ps2_data_in pass through 2-FF synchronizers. A falling edge is synchronized clock 1 -> 0 between consecutive cycles, so edge detection adds 3 cycles of latency.
- Frame latched at accept: start 0, D0..D7 (LSB first), odd parity (~^tx_data), stop 1.
- IDLE: on tx_valid, latch the frame and clear the retry count. Next cycle enter INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then enter START.
- START: data_oe=1 (start bit) and clk_oe=0 in the same cycle. Wait for the first falling edge; on it, drive D0 and enter SHIFT.
- SHIFT: bit index 0..9. On each falling edge, advance and drive the next bit as data_oe = ~bit. Order is D1..D7, parity, stop (data_oe=0). The falling edge after the stop bit moves to ACK and samples the data line on that same edge.
- ACK: synchronized data = 0 at that edge is an ACK; enter WAIT_IDLE. Data = 1 is a NACK and is treated as an error.
- WAIT_IDLE: wait until synchronized clock = 1 and data = 1, then pulse tx_done and return to IDLE.
- Timeout counter (20 bit) clears on state entry and on every falling edge. If it reaches START_TIMEOUT in START, or EDGE_TIMEOUT in SHIFT/ACK/WAIT_IDLE, that is an error.
- On error: release both lines the same cycle, pulse tx_error, return to IDLE, subject to the retry rule below.
- tx_valid while not IDLE is ignored; the byte is not queued.
- A falling edge on the same cycle the timeout is reached is treated as the edge; the edge wins.
- Line enables are registered outputs, glitch-free, and never both released mid-frame except during the stop bit.

Optional Feature:
PS2_TX_RETRY_EN:
- Defined: on error, if retry count < MAX_RETRY, increment it, keep the latched frame, and re-enter INHIBIT without pulsing tx_error. tx_error pulses only after MAX_RETRY+1 failed attempts.
- Undefined: no retry logic or counter. The first error pulses tx_error and returns to IDLE.

Test Plan:
- tx_data=0xED, device model clocks at 12 kHz and ACKs -> clk_oe high for 5000 cycles. Data levels on falling edges are 1,0,1,1,0,1,1,1, parity 1, stop released. One tx_done pulse, tx_error stays 0.
- tx_data=0x01 -> parity bit 0 (data_oe=1 during parity), ACK -> tx_done.
- Device never clocks after release -> tx_error exactly 750000 cycles after START entry. Lines released. Retry disabled.
- Device holds data high at the 11th edge (NACK) -> tx_error. With PS2_TX_RETRY_EN and MAX_RETRY=2, three INHIBIT phases occur before a single tx_error.
- Device stops after the 4th edge -> tx_error 30000 cycles after that edge. tx_valid pulsed mid-frame is ignored. Next 0xFF after return to IDLE sends parity 1.
- reset driven low mid-SHIFT -> both enables 0 and tx_ready=1 asynchronously. No done/error pulse.
